// File: rtl/riscv_tag_check.sv
// Tag-check unit: flags tagged operands on stores, loads and jalr,
// raises a held exception request and keeps violation statistics.
module riscv_tag_check #(
    parameter int TCR_ST_ADDR = 0,
    parameter int TCR_ST_SRC  = 1,
    parameter int TCR_LD_ADDR = 2,
    parameter int TCR_JALR    = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      tcr_i,
    input  logic             check_valid_i,
    input  logic [1:0]       check_type_i,
    input  logic             tag_a_i,
    input  logic             tag_b_i,
    input  logic [31:0]      pc_i,
    input  logic             exc_ack_i,
    input  logic             clear_i,
    output logic             exc_req_o,
    output logic [31:0]      exc_pc_o,
    output logic [1:0]       exc_cause_o,
    output logic             stall_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] viol_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   viol;
    logic   accept;

    // Detect a tag violation for the instruction class currently in EX.
    always_comb begin
        viol = 1'b0;
        if (check_valid_i) begin
            unique case (check_type_i)
                2'b00: viol = (tcr_i[TCR_ST_ADDR] & tag_a_i)
                            | (tcr_i[TCR_ST_SRC] & tag_b_i);
                2'b01: viol = tcr_i[TCR_LD_ADDR] & tag_a_i;
                2'b10: viol = tcr_i[TCR_JALR] & tag_a_i;
                default: viol = 1'b0;
            endcase
        end
    end

    // Only one violation may be outstanding; later ones are dropped.
    assign accept = (state == IDLE) && viol;

    // Next-state logic: request is held until the controller acks it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (viol) state_nxt = REQ;
            REQ:  if (exc_ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign exc_req_o = (state == REQ);
    assign stall_o   = (state == REQ);

    // Capture the offending PC and class on acceptance; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_pc_o    <= '0;
            exc_cause_o <= '0;
        end else if (accept) begin
            exc_pc_o    <= pc_i;
            exc_cause_o <= check_type_i;
        end
    end

    // Saturating violation counter and sticky flag; a same-cycle
    // accept wins over clear so the new violation is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            viol_cnt_o <= '0;
            sticky_o   <= 1'b0;
        end else if (accept) begin
            sticky_o <= 1'b1;
            if (clear_i)
                viol_cnt_o <= CNT_W'(1);
            else if (viol_cnt_o != {CNT_W{1'b1}})
                viol_cnt_o <= viol_cnt_o + CNT_W'(1);
        end else if (clear_i) begin
            viol_cnt_o <= '0;
            sticky_o   <= 1'b0;
        end
    end

endmodule
